// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-256 key-schedule definitions: the fixed schedule sizes, the round
// key and cipher key types, the sequencer state enum, and the GF(2^8)
// helpers that the key expansion step uses to form S-box values.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR        = 14;
    localparam int AES_NUM_RK    = 15;
    localparam int AES_EXP_STEPS = 7;

    // Round-constant index of the final expansion step
    localparam logic [3:0] RC_LAST = 4'(AES_EXP_STEPS - 1);

    typedef logic [127:0] rk_t;
    typedef logic [255:0] key256_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gfXtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add)
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = gfXtime(sh);
        end
        return acc;
    endfunction

    // S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by
    // the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = x;
        for (int i = 1; i < 8; i++) begin
            p   = gfMul(p, p);
            inv = gfMul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/keyExpansion.sv
// -----------------------------------------------------------------------------
// keyExpansion
// One combinational AES-256 key-expansion step: from eight schedule words
// w[i..i+7] it produces the next eight words w[i+8..i+15].
// Ports:
//   key    in  256  current eight words, bits [255:224] are the oldest word
//   rc     in  4    round-constant index (rcon = 01 << rc)
//   keyout out 256  next eight words, same ordering as key
// -----------------------------------------------------------------------------
module keyExpansion
    import aes_pkg::*;
(
    input  key256_t    key,
    input  logic [3:0] rc,
    output key256_t    keyout
);

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w [0:7];
    logic [31:0] n [0:7];
    logic [7:0]  rcon;
    logic [31:0] rotTemp;
    logic [31:0] subTemp;

    // The first half of the new words is seeded by RotWord/SubWord/rcon of the
    // newest word; the second half is seeded by SubWord alone of new word 3.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = key[255 - 32*i -: 32];
        end
        rcon    = 8'h01 << rc;
        rotTemp = subWord({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h000000};
        n[0]    = w[0] ^ rotTemp;
        n[1]    = w[1] ^ n[0];
        n[2]    = w[2] ^ n[1];
        n[3]    = w[3] ^ n[2];
        subTemp = subWord(n[3]);
        n[4]    = w[4] ^ subTemp;
        n[5]    = w[5] ^ n[4];
        n[6]    = w[6] ^ n[5];
        n[7]    = w[7] ^ n[6];
        keyout  = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    end

endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// aes256_key_schedule_ctrl
// Sequencer for AES-256 key expansion. Latches a 256-bit key, runs the
// keyExpansion step seven times and stores the 15 round keys in a register
// file read through a registered random-access port.
// Ports:
//   clk        in  1    clock, rising edge
//   rst        in  1    synchronous active-high reset
//   key_in     in  256  cipher key, bits [255:224] are w0
//   start      in  1    expand key_in (accepted only when idle)
//   busy       out 1    expansion in progress
//   done       out 1    one-cycle pulse when the schedule is complete
//   keys_valid out 1    register file holds a complete schedule
//   rd_rev     in  1    (only with AES_KS_REVERSE_EN) read index 14 - rd_idx
//   rd_idx     in  4    round-key index 0..14
//   rd_key     out 128  registered round key, zero when invalid/out of range
// Build option: define AES_KS_REVERSE_EN to add the rd_rev reverse-read port.
// -----------------------------------------------------------------------------
module aes256_key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  key256_t    key_in,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       keys_valid,
`ifdef AES_KS_REVERSE_EN
    input  logic       rd_rev,
`endif
    input  logic [3:0] rd_idx,
    output rk_t        rd_key
);

    ks_state_e  state_q, state_d;
    logic [3:0] rc_q, rc_d;
    logic       keys_valid_q, keys_valid_d;
    logic       done_q, done_d;
    rk_t        rd_key_q, rd_key_d;
    key256_t    cur_q;
    rk_t        rk_q [0:AES_NUM_RK-1];

    logic       acceptStart;
    logic       expandStep;
    logic       lastStep;
    key256_t    keyOut;
    logic [3:0] hiIdx;
    logic [3:0] loIdx;
    logic [3:0] effIdx;
    logic       inRange;
    rk_t        rdSel;

    keyExpansion uKeyExp (
        .key    (cur_q),
        .rc     (rc_q),
        .keyout (keyOut)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on start, return after the seventh step
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_EXPAND;
            ST_EXPAND: if (rc_q == RC_LAST) state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and internal step strobes
    always_comb begin
        busy        = 1'b0;
        acceptStart = 1'b0;
        expandStep  = 1'b0;
        lastStep    = 1'b0;
        case (state_q)
            ST_IDLE:   acceptStart = start;
            ST_EXPAND: begin
                busy       = 1'b1;
                expandStep = 1'b1;
                lastStep   = (rc_q == RC_LAST);
            end
        endcase
    end

    // Control next-state; rc wraps to 0 after the last step so the expansion
    // block only ever sees indices 0..6
    always_comb begin
        rc_d         = rc_q;
        keys_valid_d = keys_valid_q;
        done_d       = lastStep;
        if (acceptStart) begin
            rc_d         = 4'd0;
            keys_valid_d = 1'b0;
        end else if (expandStep) begin
            rc_d = lastStep ? 4'd0 : rc_q + 4'd1;
            if (lastStep) begin
                keys_valid_d = 1'b1;
            end
        end
    end

    // Read path: an out-of-range raw index returns zero even when reversed
    always_comb begin
`ifdef AES_KS_REVERSE_EN
        effIdx = rd_rev ? (4'(AES_NR) - rd_idx) : rd_idx;
`else
        effIdx = rd_idx;
`endif
        inRange = (rd_idx <= 4'(AES_NR));
        rdSel   = '0;
        for (int i = 0; i < AES_NUM_RK; i++) begin
            if (4'(i) == effIdx) begin
                rdSel = rk_q[i];
            end
        end
        rd_key_d = (keys_valid_q && inRange) ? rdSel : '0;
    end

    // Control and read registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q         <= 4'd0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_key_q     <= '0;
        end else begin
            rc_q         <= rc_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
            rd_key_q     <= rd_key_d;
        end
    end

    // Step rc writes rk[2+2rc] and rk[3+2rc]; the lower half of the last step
    // would be rk15 and is dropped
    assign hiIdx = 4'd2 + (rc_q << 1);
    assign loIdx = hiIdx + 4'd1;

    // Key datapath and round-key file; unreset because keys_valid masks them
    always_ff @(posedge clk) begin
        if (acceptStart) begin
            cur_q    <= key_in;
            rk_q[0]  <= key_in[255:128];
            rk_q[1]  <= key_in[127:0];
        end else if (expandStep) begin
            cur_q <= keyOut;
            for (int i = 2; i < AES_NUM_RK; i++) begin
                if (4'(i) == hiIdx) begin
                    rk_q[i] <= keyOut[255:128];
                end
                if (4'(i) == loIdx && !lastStep) begin
                    rk_q[i] <= keyOut[127:0];
                end
            end
        end
    end

    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule
